// File: rtl/trng_com_pkg.sv
// trng_com_pkg
// Shared constants for the TRNG byte link (8N1, LSB first) and the
// receiver line-FSM state encoding. The default bit period is also
// used by the transmitter so both ends agree.
package trng_com_pkg;

    localparam int   DATA_BITS           = 8;
    localparam logic START_LEVEL         = 1'b0;
    localparam logic STOP_LEVEL          = 1'b1;
    localparam logic IDLE_LEVEL          = 1'b1;
    localparam int   CLK_PER_BIT_DEFAULT = 16;

    // Receiver line FSM
    // state    | meaning
    // ST_IDLE  | line idle, waiting for a falling edge
    // ST_START | half-bit wait, then confirm start bit is low
    // ST_DATA  | sample 8 data bits at bit centres, LSB first
    // ST_STOP  | sample stop bit; push byte or flag framing error
    // ST_BREAK | line stuck low after framing error, wait for high
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/trng_com_rx_fifo.sv
// trng_com_rx_fifo
// Circular byte FIFO. Push and pop are expected to be already qualified
// by the caller (no push when full unless popping, no pop when empty).
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_push, i_push_dat  write strobe and byte
//   i_pop            remove head entry
//   o_head           head entry (0 or stale when empty)
//   o_count          number of stored entries
//   o_full, o_empty  status flags
module trng_com_rx_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_push,
    input  logic [7:0]    i_push_dat,
    input  logic          i_pop,
    output logic [7:0]    o_head,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (i_push) begin
                mem[wr_ptr] <= i_push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (i_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (i_push && !i_pop) begin
                count <= count + CW'(1);
            end else if (!i_push && i_pop) begin
                count <= count - CW'(1);
            end
        end
    end

    assign o_head  = mem[rd_ptr];
    assign o_count = count;
    assign o_full  = (count == CW'(DEPTH));
    assign o_empty = (count == '0);

endmodule

// File: rtl/trng_com_rx.sv
// trng_com_rx
// 8N1 serial receiver for the TRNG byte link with RTS_n flow control.
// Recovered bytes are buffered in a small FIFO and read out through a
// valid/read handshake.
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_serial_data     asynchronous serial line, idle high
//   o_serial_rts_n    0 = ready to receive, 1 = stop sending
//   o_dat, o_valid    FIFO head byte, FIFO not empty
//   i_read            pop head when o_valid
//   o_new_frame       pulse: good byte pushed
//   o_frame_err       pulse: stop bit sampled low
//   o_overrun         pulse: good byte dropped, FIFO full
module trng_com_rx
    import trng_com_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH  = 4,
    parameter int RTS_MARGIN  = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_serial_data,
    output logic       o_serial_rts_n,
    output logic [7:0] o_dat,
    output logic       o_valid,
    input  logic       i_read,
    output logic       o_new_frame,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int TW = $clog2(CLK_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] T_HALF   = TW'(CLK_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL   = TW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] RTS_THR  = CW'(FIFO_DEPTH - RTS_MARGIN);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 sync_1;
    logic                 sync_2;
    logic                 sync_prev;
    logic [2:0]           state;
    logic [TW-1:0]        timer;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;

    logic          fall;
    logic          tick;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          stop_bad;
    logic [CW-1:0] count;
    logic [CW-1:0] next_count;
    logic          full;
    logic          empty;

    assign fall     = sync_prev & ~sync_2;
    assign tick     = (timer == '0);
    assign push_req = (state == ST_STOP) && tick && (sync_2 == STOP_LEVEL);
    assign stop_bad = (state == ST_STOP) && tick && (sync_2 != STOP_LEVEL);
    assign pop      = i_read & ~empty;
    // A pop in the same cycle frees the slot the new byte needs.
    assign push_ok  = push_req & (~full | pop);

    always_comb begin
        next_count = count;
        if (push_ok && !pop) begin
            next_count = count + CW'(1);
        end else if (!push_ok && pop) begin
            next_count = count - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_1         <= IDLE_LEVEL;
            sync_2         <= IDLE_LEVEL;
            sync_prev      <= IDLE_LEVEL;
            state          <= ST_IDLE;
            timer          <= '0;
            bit_cnt        <= '0;
            shreg          <= '0;
            o_new_frame    <= 1'b0;
            o_frame_err    <= 1'b0;
            o_overrun      <= 1'b0;
            o_serial_rts_n <= 1'b1;
        end else begin
            sync_1         <= i_serial_data;
            sync_2         <= sync_1;
            sync_prev      <= sync_2;
            o_new_frame    <= push_ok;
            o_overrun      <= push_req & ~push_ok;
            o_frame_err    <= stop_bad;
            o_serial_rts_n <= (next_count >= RTS_THR);

            case (state)
                ST_IDLE: begin
                    if (fall) begin
                        timer <= T_HALF;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (!tick) begin
                        timer <= timer - TW'(1);
                    end else if (sync_2 != START_LEVEL) begin
                        state <= ST_IDLE;
                    end else begin
                        timer   <= T_FULL;
                        bit_cnt <= '0;
                        state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (!tick) begin
                        timer <= timer - TW'(1);
                    end else begin
                        shreg[bit_cnt] <= sync_2;
                        timer          <= T_FULL;
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    // Leaving mid-stop-bit lets the next start edge be
                    // caught even if the transmitter clock runs fast.
                    if (!tick) begin
                        timer <= timer - TW'(1);
                    end else if (sync_2 == STOP_LEVEL) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (sync_2 == IDLE_LEVEL) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    trng_com_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_push     (push_ok),
        .i_push_dat (shreg),
        .i_pop      (pop),
        .o_head     (o_dat),
        .o_count    (count),
        .o_full     (full),
        .o_empty    (empty)
    );

    assign o_valid = ~empty;

endmodule

// File: tb/tb_trng_com_rx.sv
// tb_trng_com_rx
// Directed bench for trng_com_rx at CLK_PER_BIT = 16, FIFO_DEPTH = 4,
// RTS_MARGIN = 1. A frame driven starting right after posedge N has
// its stop bit sampled at cycle N+154, so the push outcome pulses are
// visible at cycle N+155 (two synchronizer cycles to the edge detect,
// then half a bit plus nine bits).
module tb_trng_com_rx;
    import trng_com_pkg::*;

    localparam int CPB    = 16;
    localparam int FRAME  = 10 * CPB;
    localparam int PULSE  = 155;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_serial_data;
    logic       i_read;
    logic       o_serial_rts_n;
    logic [7:0] o_dat;
    logic       o_valid;
    logic       o_new_frame;
    logic       o_frame_err;
    logic       o_overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int frame_n = 0;

    int   nf_cnt = 0, fe_cnt = 0, ov_cnt = 0;
    int   nf_cyc = 0, fe_cyc = 0, ov_cyc = 0;
    logic nf_valid = 1'b0, nf_rts = 1'b0;

    int save_nf, save_fe, save_ov;

    trng_com_rx #(
        .CLK_PER_BIT (CPB),
        .FIFO_DEPTH  (4),
        .RTS_MARGIN  (1)
    ) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_serial_data  (i_serial_data),
        .o_serial_rts_n (o_serial_rts_n),
        .o_dat          (o_dat),
        .o_valid        (o_valid),
        .i_read         (i_read),
        .o_new_frame    (o_new_frame),
        .o_frame_err    (o_frame_err),
        .o_overrun      (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (o_new_frame) begin
            nf_cnt   <= nf_cnt + 1;
            nf_cyc   <= cyc;
            nf_valid <= o_valid;
            nf_rts   <= o_serial_rts_n;
        end
        if (o_frame_err) begin
            fe_cnt <= fe_cnt + 1;
            fe_cyc <= cyc;
        end
        if (o_overrun) begin
            ov_cnt <= ov_cnt + 1;
            ov_cyc <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Drives start, 8 data bits LSB first, stop; ncyc cycles in total.
    // rd_at_s raises i_read only during the stop-sample cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input bit rd_at_s, input int ncyc);
        logic [9:0] bits;
        bits    = {stop, d, START_LEVEL};
        frame_n = cyc;
        for (int i = 0; i < ncyc; i++) begin
            i_serial_data = bits[i / CPB];
            i_read        = rd_at_s && (i == PULSE - 1);
            @(posedge i_clk);
            #1;
        end
        i_read = 1'b0;
    endtask

    task automatic pop_one();
        i_read = 1'b1;
        @(posedge i_clk);
        #1;
        i_read = 1'b0;
    endtask

    initial begin
        i_reset       = 1'b1;
        i_serial_data = 1'b1;
        i_read        = 1'b0;
        idle(3);

        // reset state
        check("rst_rts_n", o_serial_rts_n, 1'b1);
        check("rst_valid", o_valid, 1'b0);
        check("rst_dat", o_dat, 8'h00);
        check("rst_pulses", {o_new_frame, o_frame_err, o_overrun}, 3'b000);
        i_reset = 1'b0;
        idle(3);
        check("post_rst_rts_n", o_serial_rts_n, 1'b0);

        // single byte, no reads
        send_frame(8'hA5, 1'b1, 1'b0, FRAME);
        idle(2);
        check("a5_nf_cnt", nf_cnt, 1);
        check("a5_nf_cyc", nf_cyc, frame_n + PULSE);
        check("a5_valid_at_pulse", nf_valid, 1'b1);
        check("a5_dat", o_dat, 8'hA5);
        check("a5_no_err", fe_cnt + ov_cnt, 0);
        pop_one();
        check("a5_popped_valid", o_valid, 1'b0);

        // half-bit glitch is a false start
        save_nf = nf_cnt;
        i_serial_data = 1'b0;
        idle(CPB / 2);
        i_serial_data = 1'b1;
        idle(24);
        check("glitch_no_nf", nf_cnt, save_nf);
        check("glitch_no_err", fe_cnt + ov_cnt, 0);
        check("glitch_valid", o_valid, 1'b0);
        check("glitch_state_idle", dut.state, ST_IDLE);
        send_frame(8'h3C, 1'b1, 1'b0, FRAME);
        idle(2);
        check("3c_nf_cyc", nf_cyc, frame_n + PULSE);
        check("3c_dat", o_dat, 8'h3C);
        pop_one();

        // framing error followed by a long break
        save_nf = nf_cnt;
        send_frame(8'h55, 1'b0, 1'b0, FRAME);
        idle(20 * CPB);
        i_serial_data = 1'b1;
        idle(2 * CPB);
        check("fe_cnt", fe_cnt, 1);
        check("fe_cyc", fe_cyc, frame_n + PULSE);
        check("fe_not_stored", nf_cnt, save_nf);
        check("fe_valid", o_valid, 1'b0);
        check("fe_no_ov", ov_cnt, 0);
        send_frame(8'h12, 1'b1, 1'b0, FRAME);
        idle(2);
        check("12_nf_cnt", nf_cnt, save_nf + 1);
        check("12_dat", o_dat, 8'h12);
        pop_one();

        // fill FIFO, RTS and overrun
        save_nf = nf_cnt;
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b1, 1'b0, FRAME);
            idle(4);
            if (k == 2) check("rts_after_2", nf_rts, 1'b0);
            if (k == 3) check("rts_after_3", nf_rts, 1'b1);
        end
        check("fill_nf_cnt", nf_cnt, save_nf + 4);
        check("fill_ov_cnt", ov_cnt, 1);
        check("fill_ov_cyc", ov_cyc, frame_n + PULSE);
        for (int k = 1; k <= 4; k++) begin
            check("fill_read_dat", o_dat, 32'(k));
            pop_one();
            if (k == 1) check("rts_count3", o_serial_rts_n, 1'b1);
            if (k == 2) check("rts_count2", o_serial_rts_n, 1'b0);
        end
        check("fill_drained", o_valid, 1'b0);

        // full FIFO with a pop in the stop-sample cycle
        for (int k = 0; k < 4; k++) begin
            send_frame(8'h0A + 8'(k), 1'b1, 1'b0, FRAME);
            idle(4);
        end
        check("full_rts", o_serial_rts_n, 1'b1);
        save_nf = nf_cnt;
        save_ov = ov_cnt;
        send_frame(8'h05, 1'b1, 1'b1, FRAME);
        idle(4);
        check("simul_no_ov", ov_cnt, save_ov);
        check("simul_nf_cnt", nf_cnt, save_nf + 1);
        check("simul_nf_cyc", nf_cyc, frame_n + PULSE);
        check("simul_rts", o_serial_rts_n, 1'b1);
        check("simul_dat0", o_dat, 8'h0B); pop_one();
        check("simul_dat1", o_dat, 8'h0C); pop_one();
        check("simul_dat2", o_dat, 8'h0D); pop_one();
        check("simul_dat3", o_dat, 8'h05); pop_one();
        check("simul_drained", o_valid, 1'b0);

        // reset during data bit 4
        send_frame(8'h77, 1'b1, 1'b0, FRAME);
        idle(4);
        check("pre_rst_valid", o_valid, 1'b1);
        save_nf = nf_cnt;
        save_fe = fe_cnt;
        save_ov = ov_cnt;
        send_frame(8'hFF, 1'b1, 1'b0, 5 * CPB + 5);
        i_reset       = 1'b1;
        i_serial_data = 1'b1;
        @(posedge i_clk);
        #1;
        check("midrst_rts_n", o_serial_rts_n, 1'b1);
        check("midrst_valid", o_valid, 1'b0);
        check("midrst_dat", o_dat, 8'h00);
        check("midrst_pulses", {o_new_frame, o_frame_err, o_overrun}, 3'b000);
        check("midrst_state", dut.state, ST_IDLE);
        i_reset = 1'b0;
        idle(2 * CPB);
        check("midrst_no_pulse", (nf_cnt - save_nf) + (fe_cnt - save_fe) + (ov_cnt - save_ov), 0);
        send_frame(8'h81, 1'b1, 1'b0, FRAME);
        idle(2);
        check("81_nf_cyc", nf_cyc, frame_n + PULSE);
        check("81_dat", o_dat, 8'h81);
        check("81_valid", o_valid, 1'b1);
        pop_one();
        check("81_drained", o_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
